// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display sequencers.
package display_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned VALUE_W = DIGIT_W * DIGITS;

  // Bit offsets of each digit within a packed 16-bit requester value.
  localparam int unsigned DIGIT0_LSB = 0;
  localparam int unsigned DIGIT1_LSB = DIGIT_W;
  localparam int unsigned DIGIT2_LSB = 2 * DIGIT_W;
  localparam int unsigned DIGIT3_LSB = 3 * DIGIT_W;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } arb_state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/display_arbiter_hold_timer.sv
// Tick-driven saturating hold counter; clear reloads 0, or 1 when a tick coincides.
module hold_timer #(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic clr_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(tick_i);
    end else if (tick_i && (cnt_q != HOLD)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // done is registered alongside the counter so it always equals (cnt_q == HOLD).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == HOLD);
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/display_arbiter.sv
// Two-requester arbiter for the 4-digit display with a minimum hold in tick pulses.
// Define DISPLAY_ARB_FIXED_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned TICK_CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] req,
  input  logic [VALUE_W-1:0] value0,
  input  logic [VALUE_W-1:0] value1,
  output logic [NUM_REQ-1:0] grant,
  output logic [DIGIT_W-1:0] digit0,
  output logic [DIGIT_W-1:0] digit1,
  output logic [DIGIT_W-1:0] digit2,
  output logic [DIGIT_W-1:0] digit3,
  output logic               blank
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [VALUE_W-1:0] digits_q;
  logic               blank_q;
  logic               hold_done;
  logic               timer_clr_c;
  logic               owner_c;
  logic               winner_c;
  logic               may_preempt_c;
`ifndef DISPLAY_ARB_FIXED_PRIO_EN
  logic               rr_q, rr_d;
`endif

  hold_timer #(
    .HOLD_TICKS (HOLD_TICKS),
    .CNT_W      (TICK_CNT_W)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (reset),
    .tick_i (tick),
    .clr_i  (timer_clr_c),
    .done_o (hold_done)
  );

  // Next-state: owner_c is the current grantee index while in SHOW.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    timer_clr_c   = 1'b0;
    owner_c       = grant_q[1];
    winner_c      = 1'b0;
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
    may_preempt_c = grant_q[1];
`else
    may_preempt_c = 1'b1;
    rr_d          = rr_q;
`endif

    case (state_q)
      IDLE: begin
        if (|req) begin
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
          winner_c = ~req[0];
`else
          winner_c = (&req) ? rr_q : req[1];
          rr_d     = ~winner_c;
`endif
          state_d     = SHOW;
          grant_d     = onehot(winner_c);
          timer_clr_c = 1'b1;
        end
      end
      SHOW: begin
        if (!req[owner_c]) begin
          timer_clr_c = 1'b1;
          if (req[~owner_c]) begin
            grant_d = onehot(~owner_c);
`ifndef DISPLAY_ARB_FIXED_PRIO_EN
            rr_d    = owner_c;
`endif
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (req[~owner_c] && hold_done && may_preempt_c) begin
          timer_clr_c = 1'b1;
          grant_d     = onehot(~owner_c);
`ifndef DISPLAY_ARB_FIXED_PRIO_EN
          rr_d        = owner_c;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
`ifndef DISPLAY_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifndef DISPLAY_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Display data follows the registered grant one cycle later; digits hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_q <= '0;
      blank_q  <= 1'b1;
    end else begin
      blank_q <= ~|grant_q;
      if (grant_q[0]) begin
        digits_q <= value0;
      end else if (grant_q[1]) begin
        digits_q <= value1;
      end
    end
  end

  assign grant  = grant_q;
  assign blank  = blank_q;
  assign digit0 = digits_q[DIGIT0_LSB +: DIGIT_W];
  assign digit1 = digits_q[DIGIT1_LSB +: DIGIT_W];
  assign digit2 = digits_q[DIGIT2_LSB +: DIGIT_W];
  assign digit3 = digits_q[DIGIT3_LSB +: DIGIT_W];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a cycle model queues expected outputs each edge.
module tb_display_arbiter;

  localparam int unsigned HOLD = 3;
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  grant;
    logic [15:0] digits;
    logic        blank;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [1:0]  req;
  logic [15:0] value0;
  logic [15:0] value1;
  logic [1:0]  grant;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic        blank;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int   m_owner;
  int   m_cnt;
  int   m_rr;
  logic [15:0] m_digits;

  bit   tick_en;
  int   phase;

  display_arbiter #(
    .HOLD_TICKS (HOLD),
    .TICK_CNT_W (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .req    (req),
    .value0 (value0),
    .value1 (value1),
    .grant  (grant),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .blank  (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one expected output set per rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner  = -1;
      m_cnt    = 0;
      m_rr     = 0;
      m_digits = '0;
      sb.delete();
    end else begin
      int   o;
      int   nxt;
      bit   clr;
      bit   done;
      exp_t e;
      o    = m_owner;
      nxt  = o;
      clr  = 1'b0;
      done = (m_cnt == HOLD);
      if (o < 0) begin
        if (req != 2'b00) begin
          if (req == 2'b11) nxt = FIXED ? 0 : m_rr;
          else nxt = req[1] ? 1 : 0;
          clr = 1'b1;
        end
      end else if (!req[o]) begin
        nxt = req[1-o] ? 1 - o : -1;
        clr = 1'b1;
      end else if (req[1-o] && done && (!FIXED || o == 1)) begin
        nxt = 1 - o;
        clr = 1'b1;
      end
      if (nxt >= 0 && nxt != o) m_rr = 1 - nxt;
      if (clr) m_cnt = tick ? 1 : 0;
      else if (tick && m_cnt < HOLD) m_cnt = m_cnt + 1;
      if (o == 0) m_digits = value0;
      else if (o == 1) m_digits = value1;
      e.blank  = (o < 0);
      e.grant  = (nxt < 0) ? 2'b00 : ((nxt == 0) ? 2'b01 : 2'b10);
      e.digits = m_digits;
      m_owner  = nxt;
      sb.push_back(e);
    end
  end

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("digits", 32'({digit3, digit2, digit1, digit0}), 32'(e.digits));
      check("blank", 32'(blank), 32'(e.blank));
    end else begin
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'd0);
      check("rst_blank", 32'(blank), 32'd1);
    end
  end

  task automatic run(input logic [1:0] r, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = r;
      if (tick_en) begin
        tick  = (phase == 9);
        phase = (phase + 1) % 10;
      end else begin
        tick = 1'b0;
      end
    end
  endtask

  task automatic pulse(input logic [1:0] r);
    @(negedge clk);
    req  = r;
    tick = 1'b1;
  endtask

  initial begin
    int r1_wins;
    reset   = 1'b0;
    req     = 2'b00;
    tick    = 1'b0;
    value0  = '0;
    value1  = '0;
    tick_en = 1'b0;
    phase   = 0;
    r1_wins = 0;

    repeat (5) @(negedge clk);
    reset = 1'b1;
    run(2'b00, 20);

    // Single requester, then release.
    value0 = 16'h1234;
    run(2'b01, 5);
    run(2'b00, 3);

    // Contention with periodic ticks; values change while shown.
    value1  = 16'hABCD;
    tick_en = 1'b1;
    phase   = 0;
    run(2'b11, 40);
    value0 = 16'h5678;
    run(2'b11, 40);
    run(2'b00, 3);

    // Early release with a tick landing on the handover cycle.
    tick_en = 1'b0;
    run(2'b01, 2);
    run(2'b11, 2);
    pulse(2'b11);
    run(2'b11, 3);
    pulse(2'b10);
    run(2'b11, 3);
    pulse(2'b11);
    run(2'b11, 3);
    pulse(2'b11);
    run(2'b11, 6);
    run(2'b00, 3);

    // Asynchronous reset in the middle of SHOW.
    run(2'b01, 2);
    run(2'b11, 4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_blank", 32'(blank), 32'd1);
    run(2'b11, 3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rr_after_rst", 32'(grant), 32'd1);
    run(2'b11, 5);
    run(2'b00, 3);

    // Randomised requests, values and ticks.
    tick_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      value0 = 16'($urandom);
      value1 = 16'($urandom);
      run(2'($urandom_range(0, 3)), $urandom_range(1, 25));
    end
    run(2'b00, 3);

`ifdef DISPLAY_ARB_FIXED_PRIO_EN
    // Requester 1 alone, then requester 0 takes over and is never preempted.
    run(2'b10, 20);
    run(2'b11, 40);
    for (int i = 0; i < 500; i++) begin
      run(2'b11, 1);
      if (grant == 2'b10) r1_wins++;
    end
    check("no_preempt_r0", 32'(r1_wins), 32'd0);
    run(2'b00, 3);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
